// File: rtl/icache_block_param.sv
// icache_block_param: N-way, S-set, multi-word-line read-only instruction cache with tree PLRU and burst line fill.
// Latency: hits return data combinationally in the cycle PrRd is raised; a miss costs at least LINE_WORDS+2 cycles.
// Backpressure: CPU_stall holds the core off during a miss; the fill waits on Com_Bus_Gnt_proc and beat strobes.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   PrRd, Address, Data_Bus     core fetch request, byte address, read word (driven only while PrRd)
//   CPU_stall                   combinational stall back to the core
//   Flush                       single-cycle invalidate of every line, aborts any miss in flight
//   Com_Bus_Req_proc/_Gnt_proc  request/grant with the shared instruction bus arbiter
//   Address_Com                 line-aligned fill address, driven only while filling
//   Data_Bus_Com, Data_in_Bus   fill word and beat strobe, only ever read here
//   Blk_accessed                way last hit or filled
//   Hit_count, Miss_count       saturating 16-bit event counters
module icache_block_param #(
  parameter int ADDR_W     = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    PrRd,
  input  logic [ADDR_W-1:0]       Address,
  inout  wire  [ADDR_W-1:0]       Data_Bus,
  output logic                    CPU_stall,
  input  logic                    Flush,
  output logic                    Com_Bus_Req_proc,
  input  logic                    Com_Bus_Gnt_proc,
  inout  wire  [ADDR_W-1:0]       Address_Com,
  inout  wire  [ADDR_W-1:0]       Data_Bus_Com,
  inout  wire                     Data_in_Bus,
  output logic [$clog2(WAYS)-1:0] Blk_accessed,
  output logic [15:0]             Hit_count,
  output logic [15:0]             Miss_count
);

  localparam int WAY_W  = $clog2(WAYS);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WW     = (WORD_W > 0) ? WORD_W : 1;
  localparam int IW     = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W  = ADDR_W - 2 - WORD_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t state, state_nxt;

  // Storage. The PLRU vector carries one spare top bit so that tree node
  // indices and way indices share a width; that bit is never set.
  logic [ADDR_W-1:0] data_mem [SETS][WAYS][LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAYS-1:0]   plru_q   [SETS];

  // Miss context latched when the miss is taken.
  logic [TAG_W-1:0] tag_q;
  logic [IW-1:0]    idx_q;
  logic [WAY_W-1:0] victim_q;
  logic [WW-1:0]    beat_q;

  // Address fields of the current fetch.
  logic [TAG_W-1:0] a_tag;
  logic [IW-1:0]    a_idx;
  logic [WW-1:0]    a_word;
  logic             unused_byte;

  assign a_tag       = Address[ADDR_W-1 -: TAG_W];
  assign unused_byte = ^Address[1:0];

  generate
    if (WORD_W > 0) begin : g_word
      assign a_word = Address[2 +: WORD_W];
    end else begin : g_no_word
      assign a_word = '0;
    end
    if (IDX_W > 0) begin : g_idx
      assign a_idx = Address[2+WORD_W +: IDX_W];
    end else begin : g_no_idx
      assign a_idx = '0;
    end
  endgenerate

  // Walk the tree from the root following each node's bit (0 = lower half).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] t);
    logic [WAY_W-1:0] v;
    int node;
    v    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      v    = (v << 1) | WAY_W'(t[node]);
      node = 2 * node + 1 + int'(t[node]);
    end
    return v;
  endfunction

  // Make every node on the accessed way's path point at the other subtree.
  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] t,
                                                 input logic [WAY_W-1:0] w);
    logic [WAYS-1:0]  r;
    logic [WAY_W-1:0] ws;
    int node;
    r    = t;
    ws   = w;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      r[node] = ~ws[WAY_W-1];
      node    = 2 * node + 1 + int'(ws[WAY_W-1]);
      ws      = ws << 1;
    end
    return r;
  endfunction

  // Lookup and victim choice on the current address.
  logic             hit_any;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    victim  = plru_victim(plru_q[a_idx]);
    // Descending scans so the lowest-index way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[a_idx][w] && (tag_mem[a_idx][w] == a_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[a_idx][w]) begin
        victim = WAY_W'(w);
      end
    end
  end

  assign hit       = PrRd & hit_any;
  assign CPU_stall = PrRd & ((state != IDLE) | ~hit_any | Flush);
  assign Data_Bus  = PrRd ? data_mem[a_idx][hit_way][a_word] : {ADDR_W{1'bz}};

  // Fill handshake.
  logic             beat_ok;
  logic             last_beat;
  logic             fill_wr;
  logic [ADDR_W-1:0] fill_addr;

  assign beat_ok   = Com_Bus_Gnt_proc & Data_in_Bus;
  assign last_beat = (beat_q == WW'(LINE_WORDS - 1));
  assign fill_wr   = (state == FILL) & beat_ok & ~Flush;
  assign fill_addr = (ADDR_W'(tag_q) << (ADDR_W - TAG_W)) | (ADDR_W'(idx_q) << (2 + WORD_W));
  assign Address_Com = (state == FILL) ? fill_addr : {ADDR_W{1'bz}};

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    Com_Bus_Req_proc = 1'b0;
    case (state)
      IDLE: begin
        if (PrRd && !hit_any) state_nxt = REQ;
      end
      REQ: begin
        Com_Bus_Req_proc = 1'b1;
        if (Com_Bus_Gnt_proc) state_nxt = FILL;
      end
      FILL: begin
        Com_Bus_Req_proc = 1'b1;
        if (beat_ok && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush wins over everything, including a miss seen in the same cycle.
    if (Flush) state_nxt = IDLE;
  end

  // Control state: valid, PLRU, miss context, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      tag_q        <= '0;
      idx_q        <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      Blk_accessed <= '0;
      Hit_count    <= '0;
      Miss_count   <= '0;
    end else if (Flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            plru_q[a_idx] <= plru_touch(plru_q[a_idx], hit_way);
            Blk_accessed  <= hit_way;
            if (Hit_count != 16'hFFFF) Hit_count <= Hit_count + 16'd1;
          end else if (PrRd) begin
            tag_q    <= a_tag;
            idx_q    <= a_idx;
            victim_q <= victim;
            if (Miss_count != 16'hFFFF) Miss_count <= Miss_count + 16'd1;
          end
        end
        REQ: begin
          // The victim is invalidated as FILL is entered so a half-written
          // line can never hit.
          if (Com_Bus_Gnt_proc) begin
            valid_q[idx_q][victim_q] <= 1'b0;
            beat_q                   <= '0;
          end
        end
        FILL: begin
          if (beat_ok) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              valid_q[idx_q][victim_q] <= 1'b1;
              plru_q[idx_q]            <= plru_touch(plru_q[idx_q], victim_q);
              Blk_accessed             <= victim_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays are not reset.
  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_mem[idx_q][victim_q][beat_q] <= Data_Bus_Com;
      if (last_beat) tag_mem[idx_q][victim_q] <= tag_q;
    end
  end

endmodule

// File: doc/icache_block_param.md
# icache_block_param

Parametrised successor to the fixed 4-way instruction cache block: an N-way, S-set, multi-word-line read-only cache per core with an internal tree pseudo-LRU, a registered miss FSM and a burst line fill over the common instruction bus. It sits between one core's fetch port and the shared instruction Com bus and arbiter. It adds the following over the current block:
- single-cycle flush;
- partial-line protection during a fill;
- saturating hit/miss counters.

## Interface
Parameters:
- ADDR_W, 32, address and data width. Byte offset is fixed at 2 bits.
- WAYS, 4, associativity. Power of 2, at least 2.
- SETS, 16, number of sets. Power of 2.
- LINE_WORDS, 4, words per line. Power of 2, at least 1.
- Address split, LSB first: [1:0] byte, then log2(LINE_WORDS) word, then log2(SETS) index, then the remaining bits as tag.

Ports:
- Single clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- PrRd  in  1  processor read request.
- Address  in  ADDR_W  fetch byte address.
- Data_Bus  inout  ADDR_W  read word. Driven only while PrRd is high, else Z.
- CPU_stall  out  1  combinational stall.
- Flush  in  1  invalidate all lines.
- Com_Bus_Req_proc  out  1  common bus request.
- Com_Bus_Gnt_proc  in  1  arbiter grant.
- Address_Com  inout  ADDR_W  line-aligned fill address. Driven in FILL, else Z.
- Data_Bus_Com  inout  ADDR_W  fill data. Never driven by this block.
- Data_in_Bus  inout  1  beat-valid strobe from L2 or a peer cache. Never driven by this block.
- Blk_accessed  out  log2(WAYS)  way last hit or filled.
- Hit_count  out  16  saturating hit counter.
- Miss_count  out  16  saturating miss counter.

## Operation
Storage:
- Data array: SETS×WAYS×LINE_WORDS words, not reset.
- Tag array: not reset.
- Valid bits: flops, reset to 0.
- PLRU: WAYS-1 bits per set, reset to 0.

Lookup:
- Combinational on the current Address.
- hit = PrRd and some valid way in the indexed set has a matching tag.

FSM states: IDLE, REQ, FILL.
- IDLE, hit: Data_Bus = word[Address word field] of the hit way; the PLRU path for that way is updated; Blk_accessed takes the way; Hit_count increments.
- IDLE, PrRd and miss: latch tag, index and victim way; go to REQ; Miss_count increments.
- Victim selection: the lowest-index invalid way; otherwise the PLRU victim.
- REQ: Com_Bus_Req_proc = 1. When Com_Bus_Gnt_proc is sampled high, clear the victim's valid bit and go to FILL with the beat counter at 0.
- FILL:
  - Com_Bus_Req_proc = 1; Address_Com = {latched tag, index, zero offsets}.
  - Each cycle with Gnt and Data_in_Bus both high, write Data_Bus_Com to word[beat] and increment the beat counter. Cycles without both are ignored.
  - On the last beat: write the tag, set valid, update PLRU, set Blk_accessed = victim, go to IDLE.

PLRU tree:
- Node 0 is the root; node k has children 2k+1 and 2k+2.
- A bit value of 0 means the victim is in the lower half.
- On an access, set each node on the accessed way's path to point away from that way.

CPU_stall = PrRd and (state ≠ IDLE or not hit or Flush).

Flush:
- Any state: clear all valid bits and reset PLRU in that cycle.
- Abort any miss and return to IDLE.
- Request drops from the next cycle.

Counters:
- Hits are not counted in a Flush cycle.
- Both counters saturate at 0xFFFF.

## Timing
Reset values:
- State IDLE.
- Com_Bus_Req_proc 0.
- Address_Com Z.
- Blk_accessed 0.
- Counters 0.
- All lines invalid, so CPU_stall = PrRd.

Hit latency: 0 cycles; data is valid in the same cycle that PrRd rises.

Miss, with miss detected at cycle 0:
- Req high from cycle 1.
- Gnt sampled at cycle g moves to FILL at g+1.
- Beats are accepted from g+1.
- The last beat at cycle b makes the line valid at b+1; CPU_stall drops at b+1 if Address is unchanged.
- Minimum miss penalty is LINE_WORDS+2 cycles.

Boundary conditions:
- PrRd falling or Address changing mid-miss: the fill completes for the latched address; lookup then resumes on the current Address.
- Gnt low mid-FILL: stay in FILL with Req high; the beat count is held.
- Victim line during a fill: never hits from the cycle FILL is entered.
- Reset mid-miss: asynchronous return to reset values.

## Test plan
Default parameters throughout.
1. Cold miss:
   - Stimulus: after reset, PrRd=1, Address=0x0000_1234; Gnt at cycle 3; beats 0xA0..0xA3.
   - Response: Req=1 at cycle 1; Address_Com=0x0000_1230 in FILL; then CPU_stall=0, Data_Bus=0xA1, Blk_accessed=0, Miss_count=1.
2. Hit:
   - Stimulus: read 0x1238, then 0x123C.
   - Response: Data_Bus=0xA2, then 0xA3, with CPU_stall=0 in the same cycle; Hit_count increases by 2.
3. PLRU victim:
   - Stimulus: fill 0x130, 0x230, 0x330, 0x430 into ways 0–3; hit 0x130; then miss 0x530.
   - Response: victim is way 2; Blk_accessed=2 after the fill; a read of 0x330 then misses.
4. Fill handshake gaps:
   - Stimulus: Data_in_Bus low for 2 cycles between beats, and Gnt low for 1 cycle while Data_in_Bus is high.
   - Response: only beats with both signals high are written; line content is correct; stall lasts until the 4th accepted beat plus 1 cycle.
5. Flush mid-FILL:
   - Stimulus: assert Flush after 2 beats.
   - Response: Req=0 the next cycle; a previously resident address misses; Miss_count increments on re-access.
6. Reset mid-FILL:
   - Stimulus: assert rst_n=0 during FILL.
   - Response: Req=0 and Address_Com=Z immediately; counters 0; a re-read misses.
